dmem_subsystem: RTL and testbench
=================================

Name: dmem_subsystem

Overview:
- Data-side memory system attached to the core's dmem port; consumes the core's load/store requests from the memory stage and returns load data on the following cycle.
- Contains a byte-writable word scratchpad RAM, size/sign handling for RV32I loads and stores, and an MMIO window with a 64-bit cycle counter and a byte TX FIFO drained through a valid/ready handshake.
- Misaligned accesses are suppressed and flagged.

Parameters:
- DEPTH, 4096, RAM depth in 32-bit words; power of two.
- MMIO_BASE, 32'hFFFF_0000, base of the MMIO window; the window is MMIO_BASE..MMIO_BASE+0xFF.
- TX_DEPTH, 8, TX FIFO entries; power of two, at least 2.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- dmemAddr  in  32  byte address
- dmemWdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0])
- dmemSize  in  3  funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
- dmemWen  in  1  store request
- dmemRen  in  1  load request
- dmemRdata  out  32  load result, sign/zero-extended, valid the cycle after dmemRen
- txData  out  8  FIFO head byte
- txValid  out  1  FIFO not empty
- txReady  in  1  consumer accepts head when txValid&&txReady
- misalignErr  out  1  sticky misaligned-access flag

Behaviour:
- Reset values: dmemRdata=0, txValid=0, txData=0, misalignErr=0, cycle counter=0, FIFO empty. RAM contents are not reset.
- Request decode uses addr[1:0]:
  - W requires addr[1:0]=00.
  - H/HU require addr[0]=0.
  - B/BU are always aligned.
- dmemWen and dmemRen both high is not legal. If it occurs, the store wins and dmemRdata reports 0.
- RAM store: byte lanes are computed from size and addr[1:0], and data is replicated into the lanes (byte to all 4 lanes, half to both halves). The write commits at the clock edge of the request cycle.
- RAM load:
  - Synchronous read; the request cycle N registers addr[1:0] and size.
  - In cycle N+1, dmemRdata = selected lane, extended according to size.
  - dmemRdata holds its value until the next dmemRen.
  - A load in cycle N+1 to an address stored in cycle N returns the new data. The RAM is read-after-write, or a bypass is used.
- RAM address = addr[log2(DEPTH)+1:2]; addresses above the RAM range alias (wrap modulo DEPTH*4). The MMIO window takes precedence over aliasing.
- MMIO, word access only. Any non-W size in the window is treated as misaligned.
  - +0x00 R: cycle counter [31:0]. +0x04 R: cycle counter [63:32]. Writes to either are ignored.
  - A read of +0x00 snapshots bits [63:32] into a shadow register. A subsequent read of +0x04 returns the shadow, so the 64-bit read is tear-free.
  - +0x08 W: push wdata[7:0] into the TX FIFO. A push when full is dropped; the FIFO is not modified and the error flag is not set. Read returns 0.
  - +0x0C R: {misalignErr, 22'b0, full, count[7:0]}. count is zero-extended and saturates at its width.
  - +0x0C W: wdata[31]=1 clears misalignErr.
  - Other window offsets: reads return 0, writes are ignored.
- Cycle counter: increments by 1 every cycle after reset; 64-bit wrap to 0.
- TX FIFO:
  - Circular buffer with extra-bit read/write pointers; txData = mem[rdPtr].
  - Pop occurs when txValid&&txReady.
  - A push and pop in the same cycle at full, or at count>=1, both take effect and count is unchanged.
  - A push and pop at empty is impossible because txValid=0, so the push proceeds.
  - txData is registered or direct from the FIFO array; it must be stable while txValid=1 and txReady=0.
- Misaligned request (load or store):
  - No RAM or MMIO side effect.
  - A load returns 0 in cycle N+1.
  - misalignErr is set in cycle N+1 and stays set until cleared by MMIO or rst.
  - If a set and a clear occur in the same cycle, set wins.
- Reset mid-operation: a load issued in the reset cycle returns 0; the FIFO is emptied and in-flight bytes are lost.

Decomposition:
- Package dmem_pkg:
  - size enum (SZ_B, SZ_H, SZ_W, SZ_BU, SZ_HU)
  - MMIO offset constants (OFF_TIMELO, OFF_TIMEHI, OFF_TXDATA, OFF_STATUS)
  - functions laneMask(size, off) and loadExtend(word, size, off)
- Sub-module sync_fifo (WIDTH, DEPTH) for the TX FIFO.
- The RAM is an inferred array inside dmem_subsystem.

Test Plan:
- SW 0xDEADBEEF @0x10; then LB @0x11, LBU @0x11, LH @0x12, LHU @0x12 -> 0xFFFFFFBE, 0x000000BE, 0xFFFFDEAD, 0x0000DEAD, each one cycle after its request.
- SB 0x7F @0x23 after SW 0 @0x20; LW @0x20 -> 0x7F000000. Back-to-back SW 0x12345678 @0x40 then LW @0x40 next cycle -> 0x12345678.
- LW @0x02 -> dmemRdata=0, misalignErr=1 next cycle, RAM @0x00 unchanged. SW 0x80000000 to STATUS -> misalignErr=0.
- txReady=0; push 9 bytes 0x01..0x09 to TXDATA (TX_DEPTH=8) -> STATUS count=8, full=1; byte 0x09 dropped. Raise txReady -> 0x01..0x08 drain in order, one per cycle, then txValid=0.
- Push and pop in the same cycle at count=3 -> count stays 3, order preserved.
- After 100 cycles from reset, LW TIMELO -> 99±pipeline offset, fixed per implementation and checked exactly. Force the counter to 0x00000000_FFFFFFFF; read LO then HI -> HI returns the value snapshotted at the LO read, no tear.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types, MMIO offsets and lane/extension helpers for the data-side memory system.
package dmem_pkg;

   typedef enum logic [2:0] {
      SZ_B  = 3'b000,
      SZ_H  = 3'b001,
      SZ_W  = 3'b010,
      SZ_BU = 3'b100,
      SZ_HU = 3'b101
   } size_e;

   // Where the registered load word came from; selects the output path in cycle N+1.
   typedef enum logic [1:0] {
      SRC_ZERO = 2'd0,
      SRC_RAM  = 2'd1,
      SRC_MMIO = 2'd2
   } rd_src_e;

   localparam logic [7:0] OFF_TIMELO = 8'h00;
   localparam logic [7:0] OFF_TIMEHI = 8'h04;
   localparam logic [7:0] OFF_TXDATA = 8'h08;
   localparam logic [7:0] OFF_STATUS = 8'h0C;

   function automatic logic [3:0] laneMask(input logic [2:0] size, input logic [1:0] off);
      logic [3:0] m;
      m = 4'b0000;
      case (size)
         SZ_B, SZ_BU: m = 4'b0001 << off;
         SZ_H, SZ_HU: m = off[1] ? 4'b1100 : 4'b0011;
         SZ_W:        m = 4'b1111;
         default:     m = 4'b0000;
      endcase
      return m;
   endfunction

   function automatic logic [31:0] storeReplicate(input logic [31:0] data, input logic [2:0] size);
      logic [31:0] r;
      r = data;
      case (size)
         SZ_B, SZ_BU: r = {4{data[7:0]}};
         SZ_H, SZ_HU: r = {2{data[15:0]}};
         default:     r = data;
      endcase
      return r;
   endfunction

   function automatic logic [31:0] loadExtend(input logic [31:0] word, input logic [2:0] size,
                                              input logic [1:0] off);
      logic [31:0] sh;
      logic [7:0]  b;
      logic [15:0] h;
      logic [31:0] r;
      sh = word >> {off, 3'b000};
      b  = sh[7:0];
      h  = off[1] ? word[31:16] : word[15:0];
      case (size)
         SZ_B:    r = {{24{b[7]}}, b};
         SZ_BU:   r = {24'b0, b};
         SZ_H:    r = {{16{h[15]}}, h};
         SZ_HU:   r = {16'b0, h};
         SZ_W:    r = word;
         default: r = 32'b0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/dmem_if.sv
// Core-facing dmem bus plus the TX byte stream, bundled for the memory subsystem.
interface dmem_if;
   logic [31:0] dmemAddr;
   logic [31:0] dmemWdata;
   logic [2:0]  dmemSize;
   logic        dmemWen;
   logic        dmemRen;
   logic [31:0] dmemRdata;
   logic [7:0]  txData;
   logic        txValid;
   logic        txReady;
   logic        misalignErr;

   // TX stream: a byte moves on every clock edge where txValid && txReady; while txValid
   // is high and txReady low, txData holds steady and txValid does not drop.
   modport master (
      output dmemAddr, dmemWdata, dmemSize, dmemWen, dmemRen, txReady,
      input  dmemRdata, txData, txValid, misalignErr
   );

   modport slave (
      input  dmemAddr, dmemWdata, dmemSize, dmemWen, dmemRen, txReady,
      output dmemRdata, txData, txValid, misalignErr
   );
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO using extra-bit pointers; head is read directly from the array.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [WIDTH-1:0]         din,
   input  logic                     pop,
   output logic [WIDTH-1:0]         dout,
   output logic                     valid,
   output logic                     full,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign count   = wr_ptr - rd_ptr;
   assign valid   = (wr_ptr != rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign do_pop  = pop && valid;
   // A pop in the same cycle frees the slot, so a push at full still lands.
   assign do_push = push && (!full || do_pop);
   assign dout    = valid ? mem[rd_ptr[AW-1:0]] : '0;

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
         if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= din;
   end
endmodule

// File: rtl/dmem_subsystem.sv
// Data memory: byte-writable scratchpad RAM, RV32I load/store sizing, and an MMIO window
// holding a 64-bit cycle counter, TX byte FIFO and status/error register.
module dmem_subsystem
   import dmem_pkg::*;
#(
   parameter int          DEPTH     = 4096,
   parameter logic [31:0] MMIO_BASE = 32'hFFFF_0000,
   parameter int          TX_DEPTH  = 8
) (
   input logic clk,
   input logic rst,
   dmem_if.slave bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(TX_DEPTH) + 1;

   logic [31:0]   ram [DEPTH];
   logic [31:0]   ram_q;
   logic [AW-1:0] ram_idx;
   logic [3:0]    lanes;
   logic [31:0]   wrep;

   logic          in_win;
   logic [7:0]    off8;
   logic          mis;
   logic          bad;
   logic          ram_we;
   logic          ram_re;
   logic          mmio_wr;
   logic          mmio_rd;
   logic          tx_push;
   logic          err_clr;

   logic [63:0]   cycle_cnt;
   logic [31:0]   hi_shadow;
   logic          misalign_err;
   logic [31:0]   mmio_val;
   logic [31:0]   mmio_q;
   rd_src_e       src_q;
   logic [1:0]    off_q;
   logic [2:0]    size_q;

   logic          tx_full;
   logic [CW-1:0] tx_count;
   logic [31:0]   count_wide;
   logic [7:0]    count8;

   assign ram_idx = bus.dmemAddr[AW+1:2];
   assign lanes   = laneMask(bus.dmemSize, bus.dmemAddr[1:0]);
   assign wrep    = storeReplicate(bus.dmemWdata, bus.dmemSize);
   assign off8    = bus.dmemAddr[7:0];
   // The window is matched before RAM aliasing is applied, so it always wins.
   assign in_win  = (bus.dmemAddr[31:8] == MMIO_BASE[31:8]);

   always_comb begin
      mis = 1'b0;
      if (in_win) begin
         mis = (bus.dmemSize != SZ_W) || (bus.dmemAddr[1:0] != 2'b00);
      end else begin
         case (bus.dmemSize)
            SZ_W:        mis = (bus.dmemAddr[1:0] != 2'b00);
            SZ_H, SZ_HU: mis = bus.dmemAddr[0];
            default:     mis = 1'b0;
         endcase
      end
   end

   // A store alongside a load takes priority; the load side then reports zero.
   assign bad     = (bus.dmemWen || bus.dmemRen) && mis;
   assign ram_we  = bus.dmemWen && !bad && !in_win && !rst;
   assign ram_re  = bus.dmemRen && !bus.dmemWen && !bad && !in_win;
   assign mmio_wr = bus.dmemWen && !bad && in_win;
   assign mmio_rd = bus.dmemRen && !bus.dmemWen && !bad && in_win;
   assign tx_push = mmio_wr && (off8 == OFF_TXDATA) && !rst;
   assign err_clr = mmio_wr && (off8 == OFF_STATUS) && bus.dmemWdata[31];

   assign count_wide = 32'(tx_count);
   assign count8     = (count_wide > 32'd255) ? 8'hFF : count_wide[7:0];

   always_comb begin
      mmio_val = 32'b0;
      case (off8)
         OFF_TIMELO: mmio_val = cycle_cnt[31:0];
         OFF_TIMEHI: mmio_val = hi_shadow;
         OFF_STATUS: mmio_val = {misalign_err, 22'b0, tx_full, count8};
         default:    mmio_val = 32'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (ram_we) begin
         for (int i = 0; i < 4; i++) begin
            if (lanes[i]) ram[ram_idx][i*8 +: 8] <= wrep[i*8 +: 8];
         end
      end
      if (ram_re) ram_q <= ram[ram_idx];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cycle_cnt    <= 64'b0;
         hi_shadow    <= 32'b0;
         misalign_err <= 1'b0;
         mmio_q       <= 32'b0;
         src_q        <= SRC_ZERO;
         off_q        <= 2'b00;
         size_q       <= SZ_W;
      end else begin
         cycle_cnt <= cycle_cnt + 64'd1;
         if (bad)          misalign_err <= 1'b1;
         else if (err_clr) misalign_err <= 1'b0;
         // Snapshot the upper half on a low read so a following high read cannot tear.
         if (mmio_rd && (off8 == OFF_TIMELO)) hi_shadow <= cycle_cnt[63:32];
         if (bus.dmemRen) begin
            off_q  <= bus.dmemAddr[1:0];
            size_q <= bus.dmemSize;
            if (ram_re) begin
               src_q <= SRC_RAM;
            end else if (mmio_rd) begin
               src_q  <= SRC_MMIO;
               mmio_q <= mmio_val;
            end else begin
               src_q <= SRC_ZERO;
            end
         end
      end
   end

   always_comb begin
      case (src_q)
         SRC_RAM:  bus.dmemRdata = loadExtend(ram_q, size_q, off_q);
         SRC_MMIO: bus.dmemRdata = mmio_q;
         default:  bus.dmemRdata = 32'b0;
      endcase
   end

   assign bus.misalignErr = misalign_err;

   sync_fifo #(
      .WIDTH (8),
      .DEPTH (TX_DEPTH)
   ) u_tx_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (tx_push),
      .din   (bus.dmemWdata[7:0]),
      .pop   (bus.txReady),
      .dout  (bus.txData),
      .valid (bus.txValid),
      .full  (tx_full),
      .count (tx_count)
   );
endmodule

// File: tb/tb_dmem_subsystem.sv
// Bench for dmem_subsystem: byte-level memory/FIFO model checked every cycle, plus pinned literals.
module tb_dmem_subsystem;
   import dmem_pkg::*;

   localparam logic [31:0] MB  = 32'hFFFF_0000;
   localparam int          TXD = 8;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   dmem_if bus ();

   dmem_subsystem #(
      .DEPTH     (4096),
      .MMIO_BASE (MB),
      .TX_DEPTH  (TXD)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Behavioural model state
   logic [7:0]  mem_m [int];
   logic [7:0]  exp_q [$];
   logic [63:0] cnt_m;
   logic [31:0] shadow_m;
   logic [31:0] rd_m;
   logic        err_m;
   logic        cnt_forced = 1'b0;

   int n_vec = 0;
   int n_bad = 0;
   logic chk_en = 1'b0;
   logic chk_rd = 1'b1;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
      end
   endtask

   function automatic int bi(input logic [31:0] a);
      return int'(a[13:0]);
   endfunction

   function automatic logic [7:0] rd_byte(input logic [31:0] a);
      int k;
      k = bi(a);
      return mem_m.exists(k) ? mem_m[k] : 8'h00;
   endfunction

   function automatic void wr_byte(input logic [31:0] a, input logic [7:0] d);
      mem_m[bi(a)] = d;
   endfunction

   // Apply this edge's request to the model, in byte-address terms.
   task automatic model_step();
      logic [31:0] a, w;
      logic [2:0]  sz;
      logic        wen, ren, win, bad, pop, push, clr;
      logic [7:0]  off, b;
      logic [15:0] h;
      int          cnt_pre;
      a = bus.dmemAddr; w = bus.dmemWdata; sz = bus.dmemSize;
      wen = bus.dmemWen; ren = bus.dmemRen;
      if (rst) begin
         rd_m = 32'b0; err_m = 1'b0; cnt_m = 64'b0; shadow_m = 32'b0;
         exp_q.delete();
         return;
      end
      win = (a[31:8] == MB[31:8]);
      off = a[7:0];
      if (win)                          bad = (sz != 3'b010) || (a[1:0] != 2'b00);
      else if (sz == 3'b010)            bad = (a[1:0] != 2'b00);
      else if (sz == 3'b001 || sz == 3'b101) bad = a[0];
      else                              bad = 1'b0;
      bad = bad && (wen || ren);
      cnt_pre = exp_q.size();
      pop  = (cnt_pre != 0) && bus.txReady;
      push = 1'b0;
      clr  = 1'b0;
      if (ren) rd_m = 32'b0;
      if (wen && !bad) begin
         if (win) begin
            push = (off == 8'h08) && ((cnt_pre < TXD) || pop);
            clr  = (off == 8'h0C) && w[31];
         end else begin
            wr_byte(a, w[7:0]);
            if (sz == 3'b001 || sz == 3'b010) wr_byte(a + 1, w[15:8]);
            if (sz == 3'b010) begin
               wr_byte(a + 2, w[23:16]);
               wr_byte(a + 3, w[31:24]);
            end
         end
      end else if (ren && !bad) begin
         if (win) begin
            case (off)
               8'h00: begin rd_m = cnt_m[31:0]; shadow_m = cnt_m[63:32]; end
               8'h04: rd_m = shadow_m;
               8'h0C: rd_m = {err_m, 22'b0, (cnt_pre == TXD), 8'(cnt_pre)};
               default: rd_m = 32'b0;
            endcase
         end else begin
            b = rd_byte(a);
            h = {rd_byte(a + 1), rd_byte(a)};
            case (sz)
               3'b000: rd_m = {{24{b[7]}}, b};
               3'b100: rd_m = {24'b0, b};
               3'b001: rd_m = {{16{h[15]}}, h};
               3'b101: rd_m = {16'b0, h};
               3'b010: rd_m = {rd_byte(a + 3), rd_byte(a + 2), h};
               default: rd_m = 32'b0;
            endcase
         end
      end
      if (bad)      err_m = 1'b1;
      else if (clr) err_m = 1'b0;
      if (pop)  void'(exp_q.pop_front());
      if (push) exp_q.push_back(w[7:0]);
      if (!cnt_forced) cnt_m = cnt_m + 64'd1;
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      @(negedge clk);
   endtask

   task automatic req(input logic wen, input logic ren, input logic [2:0] sz,
                      input logic [31:0] a, input logic [31:0] w);
      bus.dmemWen = wen; bus.dmemRen = ren; bus.dmemSize = sz;
      bus.dmemAddr = a; bus.dmemWdata = w;
      tick();
      bus.dmemWen = 1'b0; bus.dmemRen = 1'b0;
   endtask

   task automatic st(input logic [2:0] sz, input logic [31:0] a, input logic [31:0] w);
      req(1'b1, 1'b0, sz, a, w);
   endtask

   task automatic ld(input logic [2:0] sz, input logic [31:0] a);
      req(1'b0, 1'b1, sz, a, 32'b0);
   endtask

   task automatic pin_rd(input string name, input logic [31:0] exp);
      check(name, bus.dmemRdata, exp);
      check({name, "/model"}, rd_m, exp);
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         if (chk_rd) check("rdata", bus.dmemRdata, rd_m);
         check("txValid", 32'(bus.txValid), 32'(exp_q.size() != 0));
         check("txData", 32'(bus.txData), (exp_q.size() != 0) ? 32'(exp_q[0]) : 32'b0);
         check("misalignErr", 32'(bus.misalignErr), 32'(err_m));
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst = 1'b1;
      bus.dmemAddr = '0; bus.dmemWdata = '0; bus.dmemSize = 3'b010;
      bus.dmemWen = 1'b0; bus.dmemRen = 1'b0; bus.txReady = 1'b0;
      @(negedge clk);
      tick();
      chk_en = 1'b1;
      tick();
      check("rst_rdata", bus.dmemRdata, 32'h0);
      check("rst_txValid", 32'(bus.txValid), 32'h0);
      check("rst_txData", 32'(bus.txData), 32'h0);
      check("rst_err", 32'(bus.misalignErr), 32'h0);
      rst = 1'b0;

      // Counter: first cycle out of reset reads as 0, so the 101st cycle reads 100.
      repeat (100) tick();
      ld(SZ_W, MB + 32'(OFF_TIMELO)); pin_rd("timelo_100", 32'd100);
      ld(SZ_W, MB + 32'(OFF_TIMEHI)); pin_rd("timehi_0", 32'd0);

      st(SZ_W, 32'h10, 32'hDEADBEEF);
      ld(SZ_B,  32'h11); pin_rd("lb_11",  32'hFFFFFFBE);
      ld(SZ_BU, 32'h11); pin_rd("lbu_11", 32'h000000BE);
      ld(SZ_H,  32'h12); pin_rd("lh_12",  32'hFFFFDEAD);
      ld(SZ_HU, 32'h12); pin_rd("lhu_12", 32'h0000DEAD);

      st(SZ_W, 32'h20, 32'h0);
      st(SZ_B, 32'h23, 32'h7F);
      ld(SZ_W, 32'h20); pin_rd("sb_lane3", 32'h7F000000);
      st(SZ_W, 32'h40, 32'h12345678);
      ld(SZ_W, 32'h40); pin_rd("raw_b2b", 32'h12345678);
      st(SZ_H, 32'h42, 32'h0000BEEF);
      ld(SZ_W, 32'h40); pin_rd("sh_upper", 32'hBEEF5678);
      st(SZ_W, 32'h4010, 32'hCAFEF00D);
      ld(SZ_W, 32'h10); pin_rd("alias", 32'hCAFEF00D);
      req(1'b1, 1'b1, SZ_W, 32'h44, 32'hA5A5A5A5); pin_rd("both_zero", 32'h0);
      ld(SZ_W, 32'h44); pin_rd("both_store", 32'hA5A5A5A5);

      st(SZ_W, 32'h00, 32'h11223344);
      ld(SZ_W, 32'h02); pin_rd("mis_ld", 32'h0);
      check("mis_err_set", 32'(bus.misalignErr), 32'h1);
      st(SZ_W, 32'h02, 32'h55555555);
      ld(SZ_W, 32'h00); pin_rd("mis_st_nowrite", 32'h11223344);
      ld(SZ_W, MB + 32'h10); pin_rd("mmio_other", 32'h0);
      ld(SZ_W, MB + 32'(OFF_STATUS)); pin_rd("status_err", 32'h80000000);
      st(SZ_W, MB + 32'(OFF_STATUS), 32'h80000000);
      check("err_clr", 32'(bus.misalignErr), 32'h0);
      ld(SZ_B, MB + 32'(OFF_STATUS)); pin_rd("mmio_byte", 32'h0);
      check("mmio_byte_err", 32'(bus.misalignErr), 32'h1);
      st(SZ_W, MB + 32'(OFF_STATUS), 32'h80000000);

      // Overfill: ninth byte is dropped.
      for (int i = 1; i <= 9; i++) st(SZ_W, MB + 32'(OFF_TXDATA), 32'(i));
      ld(SZ_W, MB + 32'(OFF_STATUS)); pin_rd("status_full", 32'h00000108);
      bus.txReady = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         check("drain", 32'(bus.txData), 32'(i));
         tick();
      end
      check("drain_empty", 32'(bus.txValid), 32'h0);
      bus.txReady = 1'b0;

      for (int i = 0; i < 3; i++) st(SZ_W, MB + 32'(OFF_TXDATA), 32'h21 + 32'(i));
      bus.txReady = 1'b1;
      st(SZ_W, MB + 32'(OFF_TXDATA), 32'h24);
      bus.txReady = 1'b0;
      check("pp3_head", 32'(bus.txData), 32'h22);
      ld(SZ_W, MB + 32'(OFF_STATUS)); pin_rd("status_pp3", 32'h00000003);
      bus.txReady = 1'b1;
      for (int i = 0; i < 3; i++) begin
         check("pp3_order", 32'(bus.txData), 32'h22 + 32'(i));
         tick();
      end
      check("pp3_empty", 32'(bus.txValid), 32'h0);
      bus.txReady = 1'b0;

      for (int i = 0; i < 8; i++) st(SZ_W, MB + 32'(OFF_TXDATA), 32'h31 + 32'(i));
      bus.txReady = 1'b1;
      st(SZ_W, MB + 32'(OFF_TXDATA), 32'h39);
      bus.txReady = 1'b0;
      ld(SZ_W, MB + 32'(OFF_STATUS)); pin_rd("status_ppfull", 32'h00000108);
      bus.txReady = 1'b1;
      for (int i = 0; i < 8; i++) begin
         check("ppfull_order", 32'(bus.txData), 32'h32 + 32'(i));
         tick();
      end
      check("ppfull_empty", 32'(bus.txValid), 32'h0);
      bus.txReady = 1'b0;

      // Tear-free 64-bit read across a low-word wrap.
      force dut.cycle_cnt = 64'h0000_0000_FFFF_FFFF;
      cnt_forced = 1'b1;
      cnt_m = 64'h0000_0000_FFFF_FFFF;
      ld(SZ_W, MB + 32'(OFF_TIMELO)); pin_rd("tear_lo", 32'hFFFFFFFF);
      release dut.cycle_cnt;
      cnt_forced = 1'b0;
      cnt_m = 64'h0000_0001_0000_0000;
      ld(SZ_W, MB + 32'(OFF_TIMEHI)); pin_rd("tear_hi", 32'h0);
      tick();
      chk_rd = 1'b0;
      ld(SZ_W, MB + 32'(OFF_TIMELO));
      ld(SZ_W, MB + 32'(OFF_TIMEHI));
      chk_rd = 1'b1;
      pin_rd("hi_after_wrap", 32'h1);

      // Reset with work in flight.
      ld(SZ_W, 32'h40);
      st(SZ_W, 32'h01, 32'h0);
      st(SZ_W, MB + 32'(OFF_TXDATA), 32'h41);
      st(SZ_W, MB + 32'(OFF_TXDATA), 32'h42);
      rst = 1'b1;
      ld(SZ_W, 32'h40);
      rst = 1'b0;
      check("rstmid_rdata", bus.dmemRdata, 32'h0);
      check("rstmid_txValid", 32'(bus.txValid), 32'h0);
      check("rstmid_err", 32'(bus.misalignErr), 32'h0);
      tick();
      tick();

      chk_en = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
